// File: rtl/freq_hop_pkg.sv
// freq_hop_pkg: shared definitions for the frequency-hop scheduler.
//   - state_t: FSM state encoding (IDLE, LOAD, RUN).
//   - Default field widths and helpers giving the layout of one packed table
//     entry: {scaling, dwell, phase_inc}. phase_inc sits at bit 0.
package freq_hop_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam int DEFAULT_PHASE_WIDTH   = 24;
  localparam int DEFAULT_SCALING_WIDTH = 18;
  localparam int DEFAULT_DWELL_WIDTH   = 16;
  localparam int DEFAULT_ADDR_WIDTH    = 3;

  // Bit offset of the dwell field inside a packed entry.
  function automatic int dwell_lsb(input int phase_w);
    return phase_w;
  endfunction

  // Bit offset of the scaling field inside a packed entry.
  function automatic int scaling_lsb(input int phase_w, input int dwell_w);
    return phase_w + dwell_w;
  endfunction

  // Total packed entry width.
  function automatic int entry_width(input int phase_w, input int dwell_w, input int scaling_w);
    return phase_w + dwell_w + scaling_w;
  endfunction

endpackage

// File: rtl/freq_hop_table.sv
// freq_hop_table: flop-based hop table, one write port and one registered
// read port. Contents and read register clear to zero on reset.
// A write to the address being read in the same cycle is forwarded, so the
// read register always reflects every write up to and including this cycle.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data  write port
//   rd_addr             read address (sampled every cycle)
//   rd_data             registered read data
module freq_hop_table #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 58
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
      rd_data <= '0;
    end else begin
      if (wr_en) begin
        mem_reg[wr_addr] <= wr_data;
      end
      // Forward a same-cycle write so it is visible one cycle later.
      if (wr_en && (wr_addr == rd_addr)) begin
        rd_data <= wr_data;
      end else begin
        rd_data <= mem_reg[rd_addr];
      end
    end
  end

endmodule

// File: rtl/freq_hop_sched.sv
// freq_hop_sched: phase/scaling scheduler for freq_shift_iq.
// Steps through a table of hop entries (phase increment, dwell, scaling)
// producing a phase-continuous accumulator stream, one beat per accepted
// handshake, with zero-bubble hops between entries.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   cfg_wr_en/cfg_addr/cfg_*       table write port (any state)
//   num_entries, loop_en           run configuration, sampled in LOAD
//   start, stop                    run control pulses
//   phase_tdata/tvalid/tlast/tready  phase stream
//   scaling_tdata, entry_idx       active entry scaling and index
//   busy, done                     status (done pulses on return to IDLE)
module freq_hop_sched
  import freq_hop_pkg::*;
#(
  parameter int PHASE_WIDTH   = DEFAULT_PHASE_WIDTH,
  parameter int SCALING_WIDTH = DEFAULT_SCALING_WIDTH,
  parameter int DWELL_WIDTH   = DEFAULT_DWELL_WIDTH,
  parameter int ADDR_WIDTH    = DEFAULT_ADDR_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_wr_en,
  input  logic [ADDR_WIDTH-1:0]    cfg_addr,
  input  logic [PHASE_WIDTH-1:0]   cfg_phase_inc,
  input  logic [DWELL_WIDTH-1:0]   cfg_dwell,
  input  logic [SCALING_WIDTH-1:0] cfg_scaling,
  input  logic [ADDR_WIDTH:0]      num_entries,
  input  logic                     loop_en,
  input  logic                     start,
  input  logic                     stop,
  output logic [PHASE_WIDTH-1:0]   phase_tdata,
  output logic                     phase_tvalid,
  output logic                     phase_tlast,
  input  logic                     phase_tready,
  output logic [SCALING_WIDTH-1:0] scaling_tdata,
  output logic [ADDR_WIDTH-1:0]    entry_idx,
  output logic                     busy,
  output logic                     done
);

  localparam int ENTRY_WIDTH = entry_width(PHASE_WIDTH, DWELL_WIDTH, SCALING_WIDTH);
  localparam int DWELL_LSB   = dwell_lsb(PHASE_WIDTH);
  localparam int SCALING_LSB = scaling_lsb(PHASE_WIDTH, DWELL_WIDTH);

  localparam logic [ADDR_WIDTH:0]    MAX_ENTRIES = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]    ONE_ENTRY   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [DWELL_WIDTH-1:0] DWELL_ONE   = {{(DWELL_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DWELL_WIDTH-1:0] DWELL_TWO   = {{(DWELL_WIDTH-2){1'b0}}, 2'b10};

  // 0 entries means 1; anything above the table size means the whole table.
  function automatic logic [ADDR_WIDTH:0] clamp_num(input logic [ADDR_WIDTH:0] n);
    logic [ADDR_WIDTH:0] r;
    r = n;
    if (n == '0) begin
      r = ONE_ENTRY;
    end else if (n > MAX_ENTRIES) begin
      r = MAX_ENTRIES;
    end
    return r;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_idx(input logic [ADDR_WIDTH-1:0] idx,
                                                     input logic [ADDR_WIDTH:0]   num);
    logic [ADDR_WIDTH-1:0] r;
    if ({1'b0, idx} == (num - ONE_ENTRY)) begin
      r = '0;
    end else begin
      r = idx + 1'b1;
    end
    return r;
  endfunction

  state_t                  state_reg;
  logic [ADDR_WIDTH:0]     num_reg;
  logic                    loop_reg;
  logic                    stop_pend_reg;
  logic [PHASE_WIDTH-1:0]  inc_reg;
  logic [DWELL_WIDTH-1:0]  dwell_cnt_reg;

  logic [ADDR_WIDTH-1:0]    rd_addr;
  logic [ENTRY_WIDTH-1:0]   rd_data;
  logic [ENTRY_WIDTH-1:0]   wr_data;
  logic [PHASE_WIDTH-1:0]   pf_inc;
  logic [DWELL_WIDTH-1:0]   pf_dwell;
  logic [DWELL_WIDTH-1:0]   pf_dwell_eff;
  logic [SCALING_WIDTH-1:0] pf_scaling;

  logic                  beat_acc;
  logic                  is_last;
  logic                  run_end;
  logic                  hop;
  logic [ADDR_WIDTH-1:0] next_entry;

  assign wr_data = {cfg_scaling, cfg_dwell, cfg_phase_inc};

  // The table read register doubles as the prefetch register.
  assign pf_inc       = rd_data[PHASE_WIDTH-1:0];
  assign pf_dwell     = rd_data[DWELL_LSB +: DWELL_WIDTH];
  assign pf_scaling   = rd_data[SCALING_LSB +: SCALING_WIDTH];
  assign pf_dwell_eff = (pf_dwell == '0) ? DWELL_ONE : pf_dwell;

  assign beat_acc   = phase_tvalid & phase_tready;
  assign is_last    = ({1'b0, entry_idx} == (num_reg - ONE_ENTRY));
  assign run_end    = (state_reg == ST_RUN) & beat_acc & phase_tlast &
                      (stop_pend_reg | stop | (is_last & ~loop_reg));
  assign hop        = (state_reg == ST_RUN) & beat_acc & phase_tlast & ~run_end;
  assign next_entry = next_idx(entry_idx, num_reg);

  // Prefetch address always points at the entry that follows the one that
  // will be active next cycle, so back-to-back dwell-1 hops still find the
  // right data waiting in the read register.
  always_comb begin
    rd_addr = '0;
    case (state_reg)
      ST_LOAD: rd_addr = next_idx('0, clamp_num(num_entries));
      ST_RUN:  rd_addr = hop ? next_idx(next_entry, num_reg) : next_entry;
      default: rd_addr = '0;
    endcase
  end

  freq_hop_table #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (ENTRY_WIDTH)
  ) u_table (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (cfg_wr_en),
    .wr_addr (cfg_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      num_reg       <= ONE_ENTRY;
      loop_reg      <= 1'b0;
      stop_pend_reg <= 1'b0;
      inc_reg       <= '0;
      dwell_cnt_reg <= '0;
      phase_tdata   <= '0;
      phase_tvalid  <= 1'b0;
      phase_tlast   <= 1'b0;
      scaling_tdata <= '0;
      entry_idx     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg <= ST_LOAD;
            busy      <= 1'b1;
          end
        end

        ST_LOAD: begin
          // Read register holds entry 0 (address 0 is read while idle).
          num_reg       <= clamp_num(num_entries);
          loop_reg      <= loop_en;
          stop_pend_reg <= 1'b0;
          inc_reg       <= pf_inc;
          dwell_cnt_reg <= pf_dwell_eff;
          phase_tlast   <= (pf_dwell_eff == DWELL_ONE);
          scaling_tdata <= pf_scaling;
          entry_idx     <= '0;
          phase_tdata   <= '0;
          phase_tvalid  <= 1'b1;
          state_reg     <= ST_RUN;
        end

        ST_RUN: begin
          if (stop) begin
            stop_pend_reg <= 1'b1;
          end
          if (beat_acc) begin
            phase_tdata <= phase_tdata + inc_reg;
            if (run_end) begin
              state_reg     <= ST_IDLE;
              phase_tvalid  <= 1'b0;
              phase_tlast   <= 1'b0;
              busy          <= 1'b0;
              done          <= 1'b1;
              stop_pend_reg <= 1'b0;
            end else if (hop) begin
              entry_idx     <= next_entry;
              inc_reg       <= pf_inc;
              dwell_cnt_reg <= pf_dwell_eff;
              phase_tlast   <= (pf_dwell_eff == DWELL_ONE);
              scaling_tdata <= pf_scaling;
            end else begin
              dwell_cnt_reg <= dwell_cnt_reg - DWELL_ONE;
              phase_tlast   <= (dwell_cnt_reg == DWELL_TWO);
            end
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_hop_sched.sv
module tb_freq_hop_sched;

  localparam int PW = 24;
  localparam int SW = 18;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int NT = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cfg_wr_en = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [PW-1:0] cfg_phase_inc = '0;
  logic [DW-1:0] cfg_dwell = '0;
  logic [SW-1:0] cfg_scaling = '0;
  logic [AW:0]   num_entries = 4'd1;
  logic          loop_en = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [PW-1:0] phase_tdata;
  logic          phase_tvalid;
  logic          phase_tlast;
  logic          phase_tready = 1'b1;
  logic [SW-1:0] scaling_tdata;
  logic [AW-1:0] entry_idx;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  freq_hop_sched #(
    .PHASE_WIDTH(PW), .SCALING_WIDTH(SW), .DWELL_WIDTH(DW), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .reset(reset),
    .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr), .cfg_phase_inc(cfg_phase_inc),
    .cfg_dwell(cfg_dwell), .cfg_scaling(cfg_scaling),
    .num_entries(num_entries), .loop_en(loop_en), .start(start), .stop(stop),
    .phase_tdata(phase_tdata), .phase_tvalid(phase_tvalid), .phase_tlast(phase_tlast),
    .phase_tready(phase_tready), .scaling_tdata(scaling_tdata), .entry_idx(entry_idx),
    .busy(busy), .done(done)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;
  bit rand_rdy = 0;
  logic [PW-1:0] cap[$];
  logic [PW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Table as an array; on each clock the run is advanced using the table as
  // it stood before this cycle's write, then the write is applied.
  logic [PW-1:0] m_tbl_inc [NT];
  logic [DW-1:0] m_tbl_dw  [NT];
  logic [SW-1:0] m_tbl_sc  [NT];
  int            m_state = 0;  // 0 idle, 1 load, 2 run
  logic [PW-1:0] m_phase = '0;
  logic [PW-1:0] m_inc = '0;
  logic [SW-1:0] m_sc = '0;
  int            m_idx = 0;
  int            m_rem = 0;
  int            m_num = 1;
  bit            m_loop = 0;
  bit            m_pend = 0;
  bit            m_valid = 0;
  bit            m_done = 0;

  function automatic int clampn(input int n);
    if (n == 0) return 1;
    if (n > NT) return NT;
    return n;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NT; i++) begin
        m_tbl_inc[i] = '0; m_tbl_dw[i] = '0; m_tbl_sc[i] = '0;
      end
      m_state = 0; m_phase = '0; m_inc = '0; m_sc = '0; m_idx = 0; m_rem = 0;
      m_pend = 0; m_valid = 0; m_done = 0;
    end else begin
      m_done = 0;
      case (m_state)
        0: if (start) m_state = 1;
        1: begin
          m_num = clampn(int'(num_entries));
          m_loop = loop_en; m_pend = 0; m_idx = 0; m_phase = '0;
          m_inc = m_tbl_inc[0]; m_sc = m_tbl_sc[0];
          m_rem = (m_tbl_dw[0] == 0) ? 1 : int'(m_tbl_dw[0]);
          m_valid = 1; m_state = 2;
        end
        default: begin
          if (stop) m_pend = 1;
          if (phase_tready) begin
            m_phase = m_phase + m_inc;
            if (m_rem == 1) begin
              if (m_pend || (m_idx == m_num - 1 && !m_loop)) begin
                m_state = 0; m_valid = 0; m_done = 1; m_pend = 0;
              end else begin
                m_idx = (m_idx + 1) % m_num;
                m_inc = m_tbl_inc[m_idx]; m_sc = m_tbl_sc[m_idx];
                m_rem = (m_tbl_dw[m_idx] == 0) ? 1 : int'(m_tbl_dw[m_idx]);
              end
            end else begin
              m_rem--;
            end
          end
        end
      endcase
      if (cfg_wr_en) begin
        m_tbl_inc[cfg_addr] = cfg_phase_inc;
        m_tbl_dw[cfg_addr]  = cfg_dwell;
        m_tbl_sc[cfg_addr]  = cfg_scaling;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("valid", 32'(phase_tvalid), 32'(m_valid));
      if (m_state != 1) check("busy", 32'(busy), 32'(m_state != 0));
      check("done", 32'(done), 32'(m_done));
      if (m_valid) begin
        check("phase", 32'(phase_tdata), 32'(m_phase));
        check("tlast", 32'(phase_tlast), 32'(m_rem == 1));
        check("scaling", 32'(scaling_tdata), 32'(m_sc));
        check("entry_idx", 32'(entry_idx), 32'(m_idx));
      end
    end
  end

  // Accepted-beat capture for the literal expectations.
  always @(negedge clk) begin
    if (phase_tvalid && phase_tready) cap.push_back(phase_tdata);
  end

  // Downstream ready: random when enabled, else always ready.
  always @(posedge clk) begin
    #1;
    phase_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_entry(input int addr, input logic [PW-1:0] inc, input int dwell,
                          input logic [SW-1:0] sc);
    cfg_wr_en = 1'b1; cfg_addr = AW'(addr); cfg_phase_inc = inc;
    cfg_dwell = DW'(dwell); cfg_scaling = sc;
    tick();
    cfg_wr_en = 1'b0;
  endtask

  task automatic do_start(input int num, input bit lp);
    num_entries = (AW+1)'(num); loop_en = lp;
    cap.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Runs until done; optionally random table writes; pulses stop once when
  // stop_beats beats have been accepted (stop_beats < 0: never).
  task automatic run_until_done(input int budget, input bit rnd_wr, input int stop_beats);
    int cyc = 0;
    bit seen = 0;
    bit stopped = 0;
    while (!seen && cyc < budget) begin
      if (rnd_wr && $urandom_range(0, 3) == 0) begin
        cfg_wr_en = 1'b1; cfg_addr = AW'($urandom_range(0, NT - 1));
        cfg_phase_inc = PW'($urandom); cfg_dwell = DW'($urandom_range(0, 3));
        cfg_scaling = SW'($urandom);
      end else begin
        cfg_wr_en = 1'b0;
      end
      if (!stopped && stop_beats >= 0 && cap.size() >= stop_beats) begin
        stop = 1'b1; stopped = 1;
      end else begin
        stop = 1'b0;
      end
      tick();
      cyc++;
      if (done) seen = 1;
    end
    cfg_wr_en = 1'b0; stop = 1'b0;
    check("done_reached", 32'(seen), 32'd1);
    $display("run: %0d cycles, %0d beats, last phase 0x%0h", cyc, cap.size(),
             (cap.size() > 0) ? cap[cap.size() - 1] : '0);
  endtask

  task automatic expect_caps(input string name);
    check($sformatf("%s_len", name), 32'(cap.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
      check($sformatf("%s_beat%0d", name, i), 32'(cap[i]), 32'(exp_q[i]));
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_phase"}, 32'(phase_tdata), 32'd0);
    check({name, "_valid"}, 32'(phase_tvalid), 32'd0);
    check({name, "_tlast"}, 32'(phase_tlast), 32'd0);
    check({name, "_scaling"}, 32'(scaling_tdata), 32'd0);
    check({name, "_idx"}, 32'(entry_idx), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    tick();
    chk_en = 1;
    tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    // Single entry, no loop.
    wr_entry(0, 24'd8192, 4, 18'h0FFFF);
    do_start(1, 0);
    run_until_done(50, 0, -1);
    exp_q = '{24'd0, 24'd8192, 24'd16384, 24'd24576};
    expect_caps("single");

    // Two entries looping with random ready; stop after 7 beats.
    wr_entry(0, 24'd8192, 2, 18'h00111);
    wr_entry(1, 24'h100000, 3, 18'h00222);
    rand_rdy = 1;
    do_start(2, 1);
    run_until_done(400, 0, 7);
    rand_rdy = 0;
    exp_q = '{24'h000000, 24'h002000, 24'h004000, 24'h104000, 24'h204000,
              24'h304000, 24'h306000, 24'h308000, 24'h408000, 24'h508000};
    expect_caps("loop2");

    // Accumulator wrap.
    wr_entry(0, 24'hC00000, 4, 18'h00001);
    do_start(1, 0);
    run_until_done(50, 0, -1);
    exp_q = '{24'h000000, 24'hC00000, 24'h800000, 24'h400000};
    expect_caps("wrap");

    // Stop mid-dwell of entry 1: its remaining beats still go out.
    wr_entry(0, 24'h10, 2, 18'h5);
    wr_entry(1, 24'h100, 5, 18'h6);
    do_start(2, 1);
    run_until_done(100, 0, 4);
    exp_q = '{24'h000, 24'h010, 24'h020, 24'h120, 24'h220, 24'h320, 24'h420};
    expect_caps("stop_mid");

    // Rewrite entry 1 two cycles before entry 0's last beat: new value used.
    wr_entry(0, 24'h40, 4, 18'h7);
    wr_entry(1, 24'h400, 2, 18'h8);
    do_start(2, 0);
    tick(); tick();
    wr_entry(1, 24'h800, 2, 18'h9);
    run_until_done(50, 0, -1);
    exp_q = '{24'h000, 24'h040, 24'h080, 24'h0C0, 24'h100, 24'h900};
    expect_caps("rewrite_early");

    // Rewrite on the same cycle as the accepted tlast: old value used.
    do_start(2, 0);
    tick(); tick(); tick(); tick();
    wr_entry(1, 24'h1000, 3, 18'hA);
    run_until_done(50, 0, -1);
    expect_caps("rewrite_late");

    // Reset mid-run, then restart from the cleared table.
    do_start(2, 1);
    tick(); tick(); tick(); tick(); tick();
    check("midrun_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    check_all_zero("midrun_reset");
    reset = 1'b0;
    tick();
    do_start(0, 0);
    run_until_done(20, 0, -1);
    exp_q = '{24'h0};
    expect_caps("after_reset");

    // Randomized runs against the model.
    for (int r = 0; r < 12; r++) begin
      for (int a = 0; a < NT; a++) begin
        wr_entry(a, PW'($urandom), $urandom_range(1, 4), SW'($urandom));
      end
      rand_rdy = 1;
      do_start($urandom_range(0, 15), 1'($urandom_range(0, 1)));
      run_until_done(600, 1, $urandom_range(1, 20));
    end
    rand_rdy = 0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
